combat_referee: RTL and testbench
=================================

Name: combat_referee

Overview:
- Responder to the per-player movement/action controllers: consumes both fighters' action flags (kick, fight, dodge, jump) and proximity flags.
- Resolves hits, tracks health, and drives back each fighter's hit-reaction code (0 none, 1 dodge recoil, 2 knockback) and the p1win/p2win game-over flags.
- Sits between the two player controllers and the sprite/HUD renderer; all state advances once per frame strobe.

Parameters:
MAX_HEALTH, 100, health loaded at match start (fits 7 bits).
KICK_DMG, 15, damage per landed kick.
PUNCH_DMG, 10, damage per landed fight (punch).
KNOCK_FRAMES, 12, frames a struck player holds hit code 2.
RECOIL_FRAMES, 6, frames a dodging defender holds hit code 1.
COOLDOWN_FRAMES, 8, frames after an attack before that attacker can land again.

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk-wide strobe per video frame; all game state advances only when high
start  in  1  Enter-key level; sampled on frame_tick
p1_kick, p1_fight, p1_dodge, p1_jump  in  1 each  player 1 action flags
p2_kick, p2_fight, p2_dodge, p2_jump  in  1 each  player 2 action flags
near_x  in  1  players within 40 px horizontally
near_y  in  1  players within 50 px vertically
p1_hit  out  2  hit-reaction code driven to player 1 controller
p2_hit  out  2  hit-reaction code driven to player 2 controller
p1_health  out  7  player 1 health
p2_health  out  7  player 2 health
p1win  out  1  player 1 has won (latched)
p2win  out  1  player 2 has won (latched)
fighting  out  1  high while match FSM is in FIGHT

Behaviour:
- Reset (Reset_n low, async): FSM=WAIT, healths=MAX_HEALTH, p1_hit=p2_hit=0, p1win=p2win=0, fighting=0, cooldown and reaction counters 0, edge-detect registers 0.
- All registers change only on a Clk edge where frame_tick=1; outputs are registered and visible one Clk after that edge. With frame_tick low, every register holds.
- Match FSM:
  - WAIT: start=1 -> FIGHT.
  - FIGHT: a health reaching 0 -> OVER.
  - OVER: start=1 -> FIGHT, reloading both healths to MAX_HEALTH and clearing wins, hit codes and counters.
  - No damage is resolved in WAIT or OVER. p1_hit and p2_hit are forced to 0 in OVER.
- Attack detection, per player, at frame granularity:
  - An attack starts on a rising edge of (kick|fight) versus the previous frame's sample.
  - Kick has priority if both flags rise together.
  - Holding the flag does not re-trigger.
- An attack lands only when all hold: near_x=1, near_y=1, attacker cooldown=0, attacker hit code=0, defender hit code=0. A defender with a nonzero hit code is invulnerable.
- Landed attack outcome:
  - Defender dodge=1: no damage; defender hit code=1 for RECOIL_FRAMES frames.
  - Otherwise: defender health -= KICK_DMG or PUNCH_DMG, saturating at 0 (if health <= dmg then 0); defender hit code=2 for KNOCK_FRAMES frames.
- Any attack edge, landed or not, loads the attacker cooldown with COOLDOWN_FRAMES.
- Counters: cooldown and reaction counters decrement once per frame to 0. A hit code returns to 0 on the frame its counter reaches 0. A non-landing attack edge while cooldown is nonzero does not reload cooldown.
- Simultaneous landing: both players' attacks resolve independently in the same frame; both can take damage, and both hit codes are set.
- Win:
  - p2 health reaching 0 sets p1win; p1 health reaching 0 sets p2win.
  - Both reaching 0 in the same frame sets both (draw).
  - Wins stay latched until OVER->FIGHT restart or reset.
- jump is a qualifier input only; an airborne defender is still struck.
- fighting=1 exactly while FSM=FIGHT.
- Reset mid-knockback: all counters and codes clear immediately (async).

Test Plan:
- Reset, then start pulse on frame 1 -> fighting=1 after that tick; healths 100/100, hit codes 0.
- p1_kick rises with near_x=near_y=1, p2 idle -> next frame p2_health=85, p2_hit=2 for 12 frames, then 0; p1_kick held 20 frames gives no further damage.
- p1_fight rises while p2_dodge=1 -> p2_health unchanged, p2_hit=1 for 6 frames; a second p1 edge 3 frames later does not land (cooldown/invulnerable).
- Both players' fight rises in the same frame with near flags set -> healths 90/90, both hit codes=2.
- p2_health=5 and p1 kick lands -> p2_health=0 (saturated), p1win=1, FSM=OVER, hit codes 0; start -> healths 100/100, p1win=0.
- frame_tick held low for 50 Clk during knockback -> counters, healths and codes unchanged; Reset_n low mid-knockback -> all outputs at reset values without waiting for a Clk edge.

Source files
------------

// File: rtl/combat_referee_if.sv
// rtl/combat_referee_if.sv - frame-rate signal bundle between player controllers and the referee
interface combat_referee_if;
    logic       frame_tick;
    logic       start;
    logic       p1_kick;
    logic       p1_fight;
    logic       p1_dodge;
    logic       p1_jump;
    logic       p2_kick;
    logic       p2_fight;
    logic       p2_dodge;
    logic       p2_jump;
    logic       near_x;
    logic       near_y;
    logic [1:0] p1_hit;
    logic [1:0] p2_hit;
    logic [6:0] p1_health;
    logic [6:0] p2_health;
    logic       p1win;
    logic       p2win;
    logic       fighting;

    // Controller / bench side: drives actions, observes referee results
    modport master (
        output frame_tick, start,
        output p1_kick, p1_fight, p1_dodge, p1_jump,
        output p2_kick, p2_fight, p2_dodge, p2_jump,
        output near_x, near_y,
        input  p1_hit, p2_hit, p1_health, p2_health,
        input  p1win, p2win, fighting
    );

    // Referee side
    modport slave (
        input  frame_tick, start,
        input  p1_kick, p1_fight, p1_dodge, p1_jump,
        input  p2_kick, p2_fight, p2_dodge, p2_jump,
        input  near_x, near_y,
        output p1_hit, p2_hit, p1_health, p2_health,
        output p1win, p2win, fighting
    );
endinterface

// File: rtl/combat_referee.sv
// rtl/combat_referee.sv - two-player hit resolution, health tracking and match FSM
module combat_referee #(
    parameter int MAX_HEALTH      = 100,
    parameter int KICK_DMG        = 15,
    parameter int PUNCH_DMG       = 10,
    parameter int KNOCK_FRAMES    = 12,
    parameter int RECOIL_FRAMES   = 6,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    combat_referee_if.slave   bus
);

    localparam logic [6:0] MAX_H    = 7'(MAX_HEALTH);
    localparam logic [6:0] KICK_D   = 7'(KICK_DMG);
    localparam logic [6:0] PUNCH_D  = 7'(PUNCH_DMG);
    localparam logic [3:0] KNOCK_N  = 4'(KNOCK_FRAMES);
    localparam logic [3:0] RECOIL_N = 4'(RECOIL_FRAMES);
    localparam logic [3:0] COOL_N   = 4'(COOLDOWN_FRAMES);

    localparam logic [1:0] HIT_NONE   = 2'd0;
    localparam logic [1:0] HIT_RECOIL = 2'd1;
    localparam logic [1:0] HIT_KNOCK  = 2'd2;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FIGHT = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] p1_health_q, p1_health_d;
    logic [6:0] p2_health_q, p2_health_d;
    logic [1:0] p1_hit_q, p1_hit_d;
    logic [1:0] p2_hit_q, p2_hit_d;
    logic [3:0] p1_cd_q, p1_cd_d;
    logic [3:0] p2_cd_q, p2_cd_d;
    logic [3:0] p1_rc_q, p1_rc_d;
    logic [3:0] p2_rc_q, p2_rc_d;
    logic       p1win_q, p1win_d;
    logic       p2win_q, p2win_d;
    logic       p1_prev_q, p2_prev_q;

    // Jump only qualifies the controllers' animation; an airborne fighter is still struck
    logic unused_jump;
    assign unused_jump = bus.p1_jump | bus.p2_jump;

    // Attack edge detection and landing qualification, evaluated against last frame's state
    logic       p1_act, p2_act;
    logic       p1_edge, p2_edge;
    logic       p1_land, p2_land;
    logic [6:0] p1_dmg, p2_dmg;
    logic [6:0] p1_health_struck, p2_health_struck;

    assign p1_act  = bus.p1_kick | bus.p1_fight;
    assign p2_act  = bus.p2_kick | bus.p2_fight;
    assign p1_edge = p1_act & ~p1_prev_q;
    assign p2_edge = p2_act & ~p2_prev_q;

    assign p1_land = p1_edge & bus.near_x & bus.near_y & (p1_cd_q == 4'd0)
                   & (p1_hit_q == HIT_NONE) & (p2_hit_q == HIT_NONE);
    assign p2_land = p2_edge & bus.near_x & bus.near_y & (p2_cd_q == 4'd0)
                   & (p2_hit_q == HIT_NONE) & (p1_hit_q == HIT_NONE);

    // Kick wins when both flags rise in the same frame
    assign p1_dmg = bus.p1_kick ? KICK_D : PUNCH_D;
    assign p2_dmg = bus.p2_kick ? KICK_D : PUNCH_D;

    // Saturating damage: the struck health never wraps below zero
    assign p2_health_struck = (p2_health_q <= p1_dmg) ? 7'd0 : (p2_health_q - p1_dmg);
    assign p1_health_struck = (p1_health_q <= p2_dmg) ? 7'd0 : (p1_health_q - p2_dmg);

    // Next-state for the match FSM and all per-frame game state
    always_comb begin
        state_d     = state_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_hit_d    = p1_hit_q;
        p2_hit_d    = p2_hit_q;
        p1_cd_d     = p1_cd_q;
        p2_cd_d     = p2_cd_q;
        p1_rc_d     = p1_rc_q;
        p2_rc_d     = p2_rc_q;
        p1win_d     = p1win_q;
        p2win_d     = p2win_q;

        case (state_q)
            S_WAIT, S_OVER: begin
                // Nothing resolves outside FIGHT; reaction codes stay parked at zero
                p1_hit_d = HIT_NONE;
                p2_hit_d = HIT_NONE;
                p1_rc_d  = 4'd0;
                p2_rc_d  = 4'd0;
                p1_cd_d  = 4'd0;
                p2_cd_d  = 4'd0;
                if (bus.start) begin
                    state_d     = S_FIGHT;
                    p1_health_d = MAX_H;
                    p2_health_d = MAX_H;
                    p1win_d     = 1'b0;
                    p2win_d     = 1'b0;
                end
            end

            S_FIGHT: begin
                // Cooldown loads only from idle, so a blocked re-press cannot extend it
                if (p1_edge && (p1_cd_q == 4'd0))
                    p1_cd_d = COOL_N;
                else if (p1_cd_q != 4'd0)
                    p1_cd_d = p1_cd_q - 4'd1;

                if (p2_edge && (p2_cd_q == 4'd0))
                    p2_cd_d = COOL_N;
                else if (p2_cd_q != 4'd0)
                    p2_cd_d = p2_cd_q - 4'd1;

                // p1 striking p2
                if (p1_land) begin
                    if (bus.p2_dodge) begin
                        p2_hit_d = HIT_RECOIL;
                        p2_rc_d  = RECOIL_N;
                    end else begin
                        p2_hit_d    = HIT_KNOCK;
                        p2_rc_d     = KNOCK_N;
                        p2_health_d = p2_health_struck;
                    end
                end else if (p2_rc_q != 4'd0) begin
                    p2_rc_d = p2_rc_q - 4'd1;
                    if (p2_rc_q == 4'd1)
                        p2_hit_d = HIT_NONE;
                end

                // p2 striking p1, resolved independently of the above
                if (p2_land) begin
                    if (bus.p1_dodge) begin
                        p1_hit_d = HIT_RECOIL;
                        p1_rc_d  = RECOIL_N;
                    end else begin
                        p1_hit_d    = HIT_KNOCK;
                        p1_rc_d     = KNOCK_N;
                        p1_health_d = p1_health_struck;
                    end
                end else if (p1_rc_q != 4'd0) begin
                    p1_rc_d = p1_rc_q - 4'd1;
                    if (p1_rc_q == 4'd1)
                        p1_hit_d = HIT_NONE;
                end

                // A knockout ends the match; both zero in one frame is a draw
                if ((p1_health_d == 7'd0) || (p2_health_d == 7'd0)) begin
                    state_d  = S_OVER;
                    p1win_d  = (p2_health_d == 7'd0);
                    p2win_d  = (p1_health_d == 7'd0);
                    p1_hit_d = HIT_NONE;
                    p2_hit_d = HIT_NONE;
                    p1_rc_d  = 4'd0;
                    p2_rc_d  = 4'd0;
                    p1_cd_d  = 4'd0;
                    p2_cd_d  = 4'd0;
                end
            end

            default: state_d = S_WAIT;
        endcase
    end

    // State register: everything advances only on a frame strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_WAIT;
            p1_health_q <= MAX_H;
            p2_health_q <= MAX_H;
            p1_hit_q    <= HIT_NONE;
            p2_hit_q    <= HIT_NONE;
            p1_cd_q     <= 4'd0;
            p2_cd_q     <= 4'd0;
            p1_rc_q     <= 4'd0;
            p2_rc_q     <= 4'd0;
            p1win_q     <= 1'b0;
            p2win_q     <= 1'b0;
            p1_prev_q   <= 1'b0;
            p2_prev_q   <= 1'b0;
        end else if (bus.frame_tick) begin
            state_q     <= state_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_hit_q    <= p1_hit_d;
            p2_hit_q    <= p2_hit_d;
            p1_cd_q     <= p1_cd_d;
            p2_cd_q     <= p2_cd_d;
            p1_rc_q     <= p1_rc_d;
            p2_rc_q     <= p2_rc_d;
            p1win_q     <= p1win_d;
            p2win_q     <= p2win_d;
            p1_prev_q   <= p1_act;
            p2_prev_q   <= p2_act;
        end
    end

    assign bus.p1_hit    = p1_hit_q;
    assign bus.p2_hit    = p2_hit_q;
    assign bus.p1_health = p1_health_q;
    assign bus.p2_health = p2_health_q;
    assign bus.p1win     = p1win_q;
    assign bus.p2win     = p2win_q;
    assign bus.fighting  = (state_q == S_FIGHT);

endmodule

// File: tb/tb_combat_referee.sv
// tb/tb_combat_referee.sv - directed self-checking bench for combat_referee
module tb_combat_referee;

    logic Clk;
    logic Reset_n;
    int   n_checks;
    int   n_fails;

    combat_referee_if bus();

    combat_referee dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        @(negedge Clk) bus.frame_tick = 1'b1;
        @(negedge Clk) bus.frame_tick = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        Reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.p1_kick    = 1'b0;
        bus.p1_fight   = 1'b0;
        bus.p1_dodge   = 1'b0;
        bus.p1_jump    = 1'b0;
        bus.p2_kick    = 1'b0;
        bus.p2_fight   = 1'b0;
        bus.p2_dodge   = 1'b0;
        bus.p2_jump    = 1'b0;
        bus.near_x     = 1'b0;
        bus.near_y     = 1'b0;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_fighting", bus.fighting, 0);
        chk("rst_p1_health", bus.p1_health, 100);
        chk("rst_p2_health", bus.p2_health, 100);
        chk("rst_p1_hit", bus.p1_hit, 0);
        chk("rst_p2_hit", bus.p2_hit, 0);
        chk("rst_wins", {bus.p1win, bus.p2win}, 0);
        Reset_n = 1'b1;

        // Start the match
        bus.start = 1'b1;
        frame();
        bus.start = 1'b0;
        chk("start_fighting", bus.fighting, 1);
        chk("start_health", {bus.p1_health, bus.p2_health}, {7'd100, 7'd100});
        chk("start_hits", {bus.p1_hit, bus.p2_hit}, 0);

        // Kick lands, knockback holds 12 frames, held kick never retriggers
        bus.near_x  = 1'b1;
        bus.near_y  = 1'b1;
        bus.p1_jump = 1'b1;
        bus.p2_jump = 1'b1;
        bus.p1_kick = 1'b1;
        frame();
        chk("kick_p2_health", bus.p2_health, 85);
        chk("kick_p2_hit", bus.p2_hit, 2);
        chk("kick_p1_hit", bus.p1_hit, 0);
        repeat (11) frame();
        chk("knock_11_p2_hit", bus.p2_hit, 2);
        frame();
        chk("knock_12_p2_hit", bus.p2_hit, 0);
        repeat (8) frame();
        chk("held_kick_p2_health", bus.p2_health, 85);
        chk("held_kick_p2_hit", bus.p2_hit, 0);
        bus.p1_kick = 1'b0;
        bus.p1_jump = 1'b0;
        bus.p2_jump = 1'b0;
        frame();

        // Punch into a dodge: recoil only, second edge blocked
        bus.p1_fight = 1'b1;
        bus.p2_dodge = 1'b1;
        frame();
        chk("dodge_p2_health", bus.p2_health, 85);
        chk("dodge_p2_hit", bus.p2_hit, 1);
        bus.p1_fight = 1'b0;
        bus.p2_dodge = 1'b0;
        repeat (2) frame();
        bus.p1_fight = 1'b1;
        frame();
        chk("reedge_p2_health", bus.p2_health, 85);
        chk("reedge_p2_hit", bus.p2_hit, 1);
        bus.p1_fight = 1'b0;
        repeat (2) frame();
        chk("recoil_5_p2_hit", bus.p2_hit, 1);
        frame();
        chk("recoil_6_p2_hit", bus.p2_hit, 0);
        repeat (4) frame();

        // Simultaneous punches both land
        bus.p1_fight = 1'b1;
        bus.p2_fight = 1'b1;
        frame();
        chk("simul_p1_health", bus.p1_health, 90);
        chk("simul_p2_health", bus.p2_health, 75);
        chk("simul_hits", {bus.p1_hit, bus.p2_hit}, {2'd2, 2'd2});
        bus.p1_fight = 1'b0;
        bus.p2_fight = 1'b0;
        repeat (12) frame();
        chk("simul_clear_hits", {bus.p1_hit, bus.p2_hit}, 0);

        // Punch p2 down to 5
        for (int i = 0; i < 7; i++) begin
            bus.p1_fight = 1'b1;
            frame();
            chk("punch_p2_health", bus.p2_health, 65 - 10 * i);
            bus.p1_fight = 1'b0;
            repeat (12) frame();
        end
        chk("pre_ko_p1win", bus.p1win, 0);
        chk("pre_ko_fighting", bus.fighting, 1);

        // Kick on 5 health saturates to 0 and ends the match
        bus.p1_kick = 1'b1;
        frame();
        chk("ko_p2_health", bus.p2_health, 0);
        chk("ko_p1_health", bus.p1_health, 90);
        chk("ko_wins", {bus.p1win, bus.p2win}, 2'b10);
        chk("ko_fighting", bus.fighting, 0);
        chk("ko_hits", {bus.p1_hit, bus.p2_hit}, 0);
        frame();
        chk("over_hold_p1win", bus.p1win, 1);

        // Restart from OVER
        bus.start = 1'b1;
        frame();
        bus.start = 1'b0;
        chk("restart_fighting", bus.fighting, 1);
        chk("restart_health", {bus.p1_health, bus.p2_health}, {7'd100, 7'd100});
        chk("restart_wins", {bus.p1win, bus.p2win}, 0);
        bus.p1_kick = 1'b0;
        frame();

        // Knockback frozen while frame_tick stays low
        bus.p2_fight = 1'b1;
        frame();
        chk("kb_p1_health", bus.p1_health, 90);
        chk("kb_p1_hit", bus.p1_hit, 2);
        repeat (50) @(negedge Clk);
        chk("freeze_p1_hit", bus.p1_hit, 2);
        chk("freeze_health", {bus.p1_health, bus.p2_health}, {7'd90, 7'd100});
        repeat (11) frame();
        chk("freeze_11_p1_hit", bus.p1_hit, 2);
        frame();
        chk("freeze_12_p1_hit", bus.p1_hit, 0);

        // Async reset mid-knockback
        bus.p2_fight = 1'b0;
        frame();
        bus.p2_fight = 1'b1;
        frame();
        chk("kb2_p1_health", bus.p1_health, 80);
        chk("kb2_p1_hit", bus.p1_hit, 2);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_p1_hit", bus.p1_hit, 0);
        chk("async_p1_health", bus.p1_health, 100);
        chk("async_fighting", bus.fighting, 0);
        chk("async_wins", {bus.p1win, bus.p2win}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
